// File: rtl/clb_switch_box_cfg_pkg.sv
// sb_pkg: side indices, select codes, FSM encoding and config sizing for the switch box
package sb_pkg;
  localparam int SIDE_N = 0;
  localparam int SIDE_E = 1;
  localparam int SIDE_S = 2;
  localparam int SIDE_W = 3;
  localparam logic [1:0] SEL_OPEN = 2'd0;
  localparam logic [1:0] SEL_LEFT = 2'd1;
  localparam logic [1:0] SEL_STRAIGHT = 2'd2;
  localparam logic [1:0] SEL_RIGHT = 2'd3;
  typedef logic [1:0] state_t;
  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_LOADING = 2'd1;
  localparam state_t ST_FULL = 2'd2;
  function automatic int sb_conf_width(input int ws, input int wd, input int wq);
    return (ws + wd / 2 + wq / 4) * 8;
  endfunction
endpackage

// File: rtl/sb_track_mux.sv
// sb_track_mux: one switched track; each side picks one of the other sides' inputs or stays open
module sb_track_mux import sb_pkg::*; (
  input  logic       in_n,
  input  logic       in_e,
  input  logic       in_s,
  input  logic       in_w,
  input  logic [7:0] cfg,
  output logic       out_n,
  output logic       out_e,
  output logic       out_s,
  output logic       out_w
);
  logic [3:0] i, o;
  assign i[SIDE_N] = in_n;
  assign i[SIDE_E] = in_e;
  assign i[SIDE_S] = in_s;
  assign i[SIDE_W] = in_w;
  // a 2-bit sum wraps naturally, giving side (s+k) mod 4
  for (genvar s = 0; s < 4; s++) begin : g_side
    logic [1:0] k;
    assign k = cfg[s*2 +: 2];
    assign o[s] = (k == SEL_OPEN) ? 1'b0 : i[2'(s) + k];
  end
  assign out_n = o[SIDE_N];
  assign out_e = o[SIDE_E];
  assign out_s = o[SIDE_S];
  assign out_w = o[SIDE_W];
endmodule

// File: rtl/clb_switch_box_cfg.sv
// clb_switch_box_cfg: single/double/quad switch box with a serial shadow/active config chain
module clb_switch_box_cfg import sb_pkg::*; #(
  parameter int WS = 8,
  parameter int WD = 8,
  parameter int WQ = 8,
  parameter int REG_OUT = 0,
  parameter int CONF_WIDTH = sb_conf_width(WS, WD, WQ)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_en,
  input  logic          cfg_in,
  output logic          cfg_out,
  input  logic          cfg_commit,
  output logic          cfg_full,
  output logic          cfg_active,
  output logic          cfg_err,
  input  logic [WS-1:0] north_single_in,
  input  logic [WS-1:0] east_single_in,
  input  logic [WS-1:0] south_single_in,
  input  logic [WS-1:0] west_single_in,
  output logic [WS-1:0] north_single_out,
  output logic [WS-1:0] east_single_out,
  output logic [WS-1:0] south_single_out,
  output logic [WS-1:0] west_single_out,
  input  logic [WD-1:0] north_double_in,
  input  logic [WD-1:0] east_double_in,
  input  logic [WD-1:0] south_double_in,
  input  logic [WD-1:0] west_double_in,
  output logic [WD-1:0] north_double_out,
  output logic [WD-1:0] east_double_out,
  output logic [WD-1:0] south_double_out,
  output logic [WD-1:0] west_double_out,
  input  logic [WQ-1:0] north_quad_in,
  input  logic [WQ-1:0] east_quad_in,
  input  logic [WQ-1:0] south_quad_in,
  input  logic [WQ-1:0] west_quad_in,
  output logic [WQ-1:0] north_quad_out,
  output logic [WQ-1:0] east_quad_out,
  output logic [WQ-1:0] south_quad_out,
  output logic [WQ-1:0] west_quad_out
);
  localparam int TW = WS + WD + WQ;
  localparam int CNTW = $clog2(CONF_WIDTH + 1);
  logic [CONF_WIDTH-1:0] shadow, active;
  logic [CNTW-1:0] cnt;
  state_t state;
  logic commit_ok;
  logic [TW-1:0] n_i, e_i, s_i, w_i, n_o, e_o, s_o, w_o, n_r, e_r, s_r, w_r;
  assign commit_ok = cfg_commit && !cfg_en && state == ST_FULL;
  assign cfg_out = shadow[0];
  assign cfg_full = state == ST_FULL;
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
      active <= '0;
      cnt <= '0;
      state <= ST_EMPTY;
      cfg_active <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_commit && !commit_ok;
      if (commit_ok) begin
        active <= shadow;
        cfg_active <= 1'b1;
      end
      if (cfg_en) begin
        shadow <= {cfg_in, shadow[CONF_WIDTH-1:1]};
        if (cnt != CNTW'(CONF_WIDTH)) cnt <= cnt + 1'b1;
        state <= (int'(cnt) + 1 >= CONF_WIDTH) ? ST_FULL : ST_LOADING;
      end
    end
  end
  assign n_i = {north_quad_in, north_double_in, north_single_in};
  assign e_i = {east_quad_in, east_double_in, east_single_in};
  assign s_i = {south_quad_in, south_double_in, south_single_in};
  assign w_i = {west_quad_in, west_double_in, west_single_in};
  // l walks single/double/quad; each packed at offset O in the per-side vectors
  for (genvar l = 0; l < 3; l++) begin : g_len
    localparam int W = l == 0 ? WS : l == 1 ? WD : WQ;
    localparam int L = l == 0 ? 1 : l == 1 ? 2 : 4;
    localparam int G = W / L;
    localparam int O = l == 0 ? 0 : l == 1 ? WS : WS + WD;
    localparam int B = l == 0 ? 0 : l == 1 ? WS * 8 : (WS + WD / 2) * 8;
    localparam int H = (L - 1) * G;
    for (genvar t = 0; t < G; t++) begin : g_sw
      sb_track_mux u_mux (
        .in_n(n_i[O+t]), .in_e(e_i[O+H+t]), .in_s(s_i[O+H+t]), .in_w(w_i[O+t]),
        .cfg(active[B+t*8 +: 8]),
        .out_n(n_o[O+t]), .out_e(e_o[O+H+t]), .out_s(s_o[O+H+t]), .out_w(w_o[O+t])
      );
    end
    for (genvar g = 1; g < L; g++) begin : g_dir
      assign n_o[O+g*G +: G] = s_i[O+(g-1)*G +: G];
      assign w_o[O+g*G +: G] = e_i[O+(g-1)*G +: G];
      assign s_o[O+(g-1)*G +: G] = n_i[O+g*G +: G];
      assign e_o[O+(g-1)*G +: G] = w_i[O+g*G +: G];
    end
  end
  if (REG_OUT != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) {n_r, e_r, s_r, w_r} <= '0;
      else {n_r, e_r, s_r, w_r} <= {n_o, e_o, s_o, w_o};
    end
  end else begin : g_comb
    assign {n_r, e_r, s_r, w_r} = {n_o, e_o, s_o, w_o};
  end
  assign north_single_out = n_r[0 +: WS];
  assign east_single_out = e_r[0 +: WS];
  assign south_single_out = s_r[0 +: WS];
  assign west_single_out = w_r[0 +: WS];
  assign north_double_out = n_r[WS +: WD];
  assign east_double_out = e_r[WS +: WD];
  assign south_double_out = s_r[WS +: WD];
  assign west_double_out = w_r[WS +: WD];
  assign north_quad_out = n_r[WS+WD +: WQ];
  assign east_quad_out = e_r[WS+WD +: WQ];
  assign south_quad_out = s_r[WS+WD +: WQ];
  assign west_quad_out = w_r[WS+WD +: WQ];
endmodule
